// File: rtl/tt_um_invert_pipe.sv
// tt_um_invert_pipe: WIDTH-bit registered logic unit with four run-time modes
// (pass, invert, rising-edge toggle, masked blink). The function stage result
// then passes through a DEPTH-stage output pipeline.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   ena      tile enable; 0 holds every register, same as freeze
//   ui_in    WIDTH-bit data input
//   uo_out   WIDTH-bit data output, last pipeline stage
//   uio_in   [1:0] mode, [2] freeze, [3] synchronous clear, [7:4] unused
//   uio_out  [3:0]=0, [5:4] registered mode, [6] valid, [7] blink phase
//   uio_oe   constant 8'hF0
module tt_um_invert_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned DIV_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] ui_in,
  output logic [WIDTH-1:0] uo_out,
  input  logic [7:0]       uio_in,
  output logic [7:0]       uio_out,
  output logic [7:0]       uio_oe
);

  localparam int unsigned FILL_W = $clog2(DEPTH + 2);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH + 1);

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_INV   = 2'b01,
    MODE_TOG   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  logic [WIDTH-1:0]    in_q, in_d;
  logic [WIDTH-1:0]    in_prev_q, in_prev_d;
  mode_e               mode_q, mode_d;
  logic [WIDTH-1:0]    tog_q, tog_d;
  logic [DIV_BITS-1:0] cnt_q, cnt_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [WIDTH-1:0]    pipe_q [DEPTH];
  logic [WIDTH-1:0]    pipe_d [DEPTH];

  logic             adv;
  logic             clr;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] func;
  logic             unused_bits;

  assign adv         = ena & ~uio_in[2];
  assign clr         = uio_in[3];
  assign rise        = in_q & ~in_prev_q;
  assign unused_bits = &{1'b0, uio_in[7:4]};

  // Function stage, evaluated on the registered sample with its registered mode
  always_comb begin
    func = in_q;
    unique case (mode_q)
      MODE_PASS:  func = in_q;
      MODE_INV:   func = ~in_q;
      MODE_TOG:   func = tog_q ^ rise;
      MODE_BLINK: func = in_q & {WIDTH{cnt_q[DIV_BITS-1]}};
    endcase
  end

  // Next-state: clear beats hold, hold beats advance
  always_comb begin
    in_d      = in_q;
    in_prev_d = in_prev_q;
    mode_d    = mode_q;
    tog_d     = tog_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    pipe_d    = pipe_q;

    if (clr) begin
      in_d      = '0;
      in_prev_d = '0;
      mode_d    = mode_e'(uio_in[1:0]);
      tog_d     = '0;
      cnt_d     = '0;
      fill_d    = '0;
      pipe_d    = '{default: '0};
    end else if (adv) begin
      in_prev_d = in_q;
      in_d      = ui_in;
      mode_d    = mode_e'(uio_in[1:0]);
      // toggle state only evolves while the toggle mode is active
      if (mode_q == MODE_TOG) begin
        tog_d = tog_q ^ rise;
      end
      cnt_d = cnt_q + DIV_BITS'(1);
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
      pipe_d[0] = func;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q      <= '0;
      in_prev_q <= '0;
      mode_q    <= MODE_PASS;
      tog_q     <= '0;
      cnt_q     <= '0;
      fill_q    <= '0;
      pipe_q    <= '{default: '0};
    end else begin
      in_q      <= in_d;
      in_prev_q <= in_prev_d;
      mode_q    <= mode_d;
      tog_q     <= tog_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      pipe_q    <= pipe_d;
    end
  end

  // Outputs are pure decodes of registers; the blink phase is not pipelined
  assign uo_out  = pipe_q[DEPTH-1];
  assign uio_out = {cnt_q[DIV_BITS-1], (fill_q == FILL_MAX), mode_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_invert_pipe.sv
// Scoreboard bench for tt_um_invert_pipe (WIDTH=8, DEPTH=2, DIV_BITS=4).
// The reference model works on the list of samples accepted since the last
// clear/reset: each sample's function value is derived from the sample, the
// one before it and its index, and the output is the value DEPTH samples back.
module tb_tt_um_invert_pipe;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned DIV_BITS = 4;
  localparam int unsigned PERIOD   = 1 << DIV_BITS;
  localparam int unsigned HALF     = 1 << (DIV_BITS - 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic [WIDTH-1:0] ui_in;
  logic [WIDTH-1:0] uo_out;
  logic [7:0]       uio_in;
  logic [7:0]       uio_out;
  logic [7:0]       uio_oe;

  tt_um_invert_pipe #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .DIV_BITS(DIV_BITS)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: samples since last clear/reset
  int         m_e;
  logic [7:0] m_prev;
  logic [7:0] m_tog;
  logic [1:0] m_mode;
  logic [7:0] m_f[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add_sample(input logic [7:0] d, input logic [1:0] md, input int idx);
    logic [7:0] rise;
    logic [7:0] f;
    rise = d & ~m_prev;
    case (md)
      2'd0: f = d;
      2'd1: f = ~d;
      2'd2: begin
        f     = m_tog ^ rise;
        m_tog = m_tog ^ rise;
      end
      default: f = ((idx % PERIOD) >= HALF) ? d : 8'h00;
    endcase
    m_prev = d;
    m_f.push_back(f);
    if (m_f.size() > DEPTH + 1) void'(m_f.pop_front());
  endtask

  task automatic m_restart(input logic [1:0] md);
    m_e    = 0;
    m_prev = '0;
    m_tog  = '0;
    m_mode = md;
    m_f.delete();
    add_sample(8'h00, md, 0);
  endtask

  function automatic exp_t m_expect();
    exp_t x;
    logic valid;
    logic blink;
    valid = (m_e >= DEPTH + 1);
    blink = ((m_e % PERIOD) >= HALF);
    x.uo  = (m_f.size() == DEPTH + 1) ? m_f[0] : 8'h00;
    x.uio = {blink, valid, m_mode, 4'b0000};
    return x;
  endfunction

  // One clock of stimulus; the model consumes what the DUT sampled at the edge
  task automatic step(input logic en, input logic [7:0] ui, input logic [1:0] md,
                      input logic frz, input logic clr);
    ena    = en;
    ui_in  = ui;
    uio_in = {4'($urandom), clr, frz, md};
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_restart(2'd0);
    end else if (clr) begin
      m_restart(md);
    end else if (en && !frz) begin
      m_e++;
      m_mode = md;
      add_sample(ui, md, m_e);
    end
    exp_q.push_back(m_expect());
  endtask

  // Reset asserted between edges: outputs must clear before any clock edge
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_uo_out", uo_out, 8'h00);
    check("async_rst_uio_out", uio_out, 8'h00);
    check("async_rst_uio_oe", uio_oe, 8'hF0);
    repeat (2) step(1'b1, 8'($urandom), 2'($urandom), 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Monitor: compare each registered response against the scoreboard
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("uo_out", uo_out, x.uo);
      check("uio_out", uio_out, x.uio);
      check("uio_oe", uio_oe, 8'hF0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] tog_seq;
    int         wait_n;
    tog_seq = 6'b011010;

    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'hA5;
    uio_in = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'hF0);
    m_restart(2'd0);
    repeat (3) step(1'b1, 8'hA5, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // pass, then invert, then switch back to pass mid-stream
    repeat (5) step(1'b1, 8'hA5, 2'd0, 1'b0, 1'b0);
    repeat (4) step(1'b1, 8'h3C, 2'd1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 8'h3C, 2'd0, 1'b0, 1'b0);

    // toggle on ui_in[0] sequence 0,1,0,1,1,0
    for (int i = 0; i < 6; i++) step(1'b1, {7'b0, tog_seq[i]}, 2'd2, 1'b0, 1'b0);
    repeat (3) step(1'b1, 8'h00, 2'd2, 1'b0, 1'b0);

    // blink, full and masked
    repeat (40) step(1'b1, 8'hFF, 2'd3, 1'b0, 1'b0);
    repeat (24) step(1'b1, 8'h0F, 2'd3, 1'b0, 1'b0);

    // hold with tog=1: freeze, then ena=0, then resume
    step(1'b1, 8'h00, 2'd2, 1'b0, 1'b0);
    repeat (3) step(1'b1, 8'h01, 2'd2, 1'b0, 1'b0);
    repeat (5) step(1'b1, 8'($urandom), 2'($urandom), 1'b1, 1'b0);
    repeat (5) step(1'b0, 8'($urandom), 2'($urandom), 1'b0, 1'b0);
    repeat (6) step(1'b1, 8'h5A, 2'd2, 1'b0, 1'b0);

    // clear while frozen with tog=1 and a full pipe
    step(1'b1, 8'h00, 2'd2, 1'b0, 1'b0);
    repeat (4) step(1'b1, 8'h81, 2'd2, 1'b0, 1'b0);
    step(1'b1, 8'($urandom), 2'd1, 1'b1, 1'b1);
    repeat (5) step(1'b1, 8'h66, 2'd2, 1'b0, 1'b0);

    // randomized traffic with occasional clear, hold and reset
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 299) async_reset();
      step(($urandom_range(0, 9) != 0), 8'($urandom), 2'($urandom),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
    end

    // reset asserted mid-blink
    repeat (12) step(1'b1, 8'hFF, 2'd3, 1'b0, 1'b0);
    async_reset();
    repeat (4) step(1'b1, 8'hC3, 2'd1, 1'b0, 1'b0);

    wait_n = 0;
    while (exp_q.size() > 0 && wait_n < 10) begin
      @(negedge clk);
      wait_n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
